// File: rtl/sched_pkg.sv
// Shared scheduler constants and types, used by the per-ingress VOQ pickers and the scheduler.
package sched_pkg;

    // One VOQ per egress port, so the VOQ count equals the egress count.
    localparam int unsigned NUM_VOQ     = 4;
    localparam int unsigned NUM_INGRESS = 4;
    localparam int unsigned IDX_W       = $clog2(NUM_VOQ);

    typedef logic [IDX_W-1:0] voq_idx_t;

    // A VOQ is eligible when it holds traffic and its egress is still free this pass.
    function automatic logic [NUM_VOQ-1:0] voq_eligible(
        input logic [NUM_VOQ-1:0] empty,
        input logic [NUM_VOQ-1:0] picked
    );
        return ~empty & ~picked;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder. It rotates the request vector so that start_i lands on bit 0,
// finds the lowest set bit, and maps that offset back to an absolute index. WIDTH must be a
// power of two so that the index arithmetic wraps naturally.
module rr_prio_enc #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             none_o
);

    logic [WIDTH-1:0] req_rot;
    logic [IDX_W-1:0] off;
    logic             none;

    // Rotate right by start_i: bit i of req_rot is request (start_i + i) mod WIDTH.
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            req_rot[i] = req_i[IDX_W'(i) + start_i];
        end
    end

    // Fixed-priority encode: scanning downwards means the lowest set bit is written last.
    always_comb begin
        off  = '0;
        none = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

    // With no request the offset stays 0, so idx_o falls back to start_i.
    assign idx_o  = start_i + off;
    assign none_o = none;

endmodule

// File: rtl/voq_pick_arbiter.sv
// Per-ingress VOQ selector. Combinationally picks the first non-empty VOQ with a free egress,
// searching from the round-robin pointer, and keeps a registered copy of the last committed
// pick for debug and status readback. It never advances the pointer or claims egresses itself.
module voq_pick_arbiter
    import sched_pkg::*;
#(
    parameter int unsigned NUM_VOQ = sched_pkg::NUM_VOQ,
    parameter int unsigned IDX_W   = $clog2(NUM_VOQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   start_voq_num,
    input  logic [NUM_VOQ-1:0] voq_empty,
    input  logic [NUM_VOQ-1:0] voq_picked,
    input  logic               pick_en,
    output logic               no_available_voq,
    output logic [IDX_W-1:0]   voq_to_pick,
    output logic               last_pick_valid,
    output logic [IDX_W-1:0]   last_pick
);

    logic [NUM_VOQ-1:0] eligible;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_none;

    logic [IDX_W-1:0]   last_pick_d,       last_pick_q;
    logic               last_pick_valid_d, last_pick_valid_q;

    assign eligible = ~voq_empty & ~voq_picked;

    rr_prio_enc #(
        .WIDTH (NUM_VOQ),
        .IDX_W (IDX_W)
    ) u_rr_prio_enc (
        .req_i   (eligible),
        .start_i (start_voq_num),
        .idx_o   (pick_idx),
        .none_o  (pick_none)
    );

    // Selection is purely combinational so the scheduler can act on it in the same cycle.
    assign voq_to_pick      = pick_idx;
    assign no_available_voq = pick_none;

    // Capture the current selection only on a commit cycle; otherwise hold.
    always_comb begin
        last_pick_d       = last_pick_q;
        last_pick_valid_d = last_pick_valid_q;
        if (pick_en) begin
            last_pick_d       = pick_idx;
            last_pick_valid_d = ~pick_none;
        end
    end

    // Status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pick_q       <= '0;
            last_pick_valid_q <= 1'b0;
        end else begin
            last_pick_q       <= last_pick_d;
            last_pick_valid_q <= last_pick_valid_d;
        end
    end

    assign last_pick       = last_pick_q;
    assign last_pick_valid = last_pick_valid_q;

endmodule

// File: tb/tb_voq_pick_arbiter.sv
// Directed and exhaustive bench for voq_pick_arbiter with a scoreboard for the comb path.
module tb_voq_pick_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    typedef struct {
        logic [W-1:0] idx;
        logic         none;
        string        tag;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] start_voq_num;
    logic [N-1:0] voq_empty;
    logic [N-1:0] voq_picked;
    logic         pick_en;
    logic         no_available_voq;
    logic [W-1:0] voq_to_pick;
    logic         last_pick_valid;
    logic [W-1:0] last_pick;

    int   n_cmp;
    int   n_fail;
    exp_t sb_q[$];

    voq_pick_arbiter #(
        .NUM_VOQ (N),
        .IDX_W   (W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_voq_num    (start_voq_num),
        .voq_empty        (voq_empty),
        .voq_picked       (voq_picked),
        .pick_en          (pick_en),
        .no_available_voq (no_available_voq),
        .voq_to_pick      (voq_to_pick),
        .last_pick_valid  (last_pick_valid),
        .last_pick        (last_pick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk start, start+1, ... mod N and stop at the first eligible VOQ.
    function automatic exp_t model(input int s, input logic [N-1:0] e, input logic [N-1:0] p);
        exp_t r;
        int   j;
        r.idx  = W'(s);
        r.none = 1'b1;
        r.tag  = "";
        for (int k = 0; k < N; k++) begin
            j = (s + k) % N;
            if (r.none && !e[j] && !p[j]) begin
                r.idx  = W'(j);
                r.none = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive comb inputs, push the model's answer, then pop and compare once settled.
    task automatic apply(input string tag, input int s, input logic [N-1:0] e,
                         input logic [N-1:0] p);
        exp_t x;
        start_voq_num = W'(s);
        voq_empty     = e;
        voq_picked    = p;
        x             = model(s, e, p);
        x.tag         = tag;
        sb_q.push_back(x);
        #1;
        x = sb_q.pop_front();
        chk({x.tag, ".none"}, 32'(no_available_voq), 32'(x.none));
        chk({x.tag, ".idx"},  32'(voq_to_pick),      32'(x.idx));
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        pick_en       = 1'b0;
        start_voq_num = '0;
        voq_empty     = '1;
        voq_picked    = '0;

        // Reset state, and comb path keeps tracking while in reset.
        #2;
        chk("rst.last_pick",       32'(last_pick),       32'h0);
        chk("rst.last_pick_valid", 32'(last_pick_valid), 32'h0);
        apply("rst_comb", 2, 4'b0000, 4'b0000);
        chk("rst_comb.exp_idx", 32'(voq_to_pick), 32'h2);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed comb vectors from the plan, with hard expected constants as well.
        apply("basic", 0, 4'b0000, 4'b0000);
        chk("basic.const", 32'(voq_to_pick), 32'h0);
        apply("skip", 1, 4'b0010, 4'b0100);
        chk("skip.const", 32'(voq_to_pick), 32'h3);
        apply("wrap_a", 3, 4'b1110, 4'b0000);
        chk("wrap_a.const", 32'(voq_to_pick), 32'h0);
        apply("wrap_b", 2, 4'b1100, 4'b0001);
        chk("wrap_b.const", 32'(voq_to_pick), 32'h1);
        apply("none_mix", 2, 4'b0101, 4'b1010);
        chk("none_mix.const", {31'h0, no_available_voq}, 32'h1);
        chk("none_mix.idx_const", 32'(voq_to_pick), 32'h2);
        for (int s = 0; s < N; s++) begin
            apply("all_empty", s, 4'b1111, 4'b0000);
            apply("all_picked", s, 4'b0000, 4'b1111);
        end

        // Register path: commit a valid pick.
        @(negedge clk);
        start_voq_num = 2'd1;
        voq_empty     = 4'b1101;
        voq_picked    = 4'b0000;
        pick_en       = 1'b1;
        @(posedge clk);
        #1;
        pick_en = 1'b0;
        chk("reg.commit.last_pick",  32'(last_pick),       32'h1);
        chk("reg.commit.valid",      32'(last_pick_valid), 32'h1);

        // pick_en low: registers hold even though the selection changes.
        start_voq_num = 2'd2;
        voq_empty     = 4'b0000;
        @(posedge clk);
        #1;
        chk("reg.hold.last_pick", 32'(last_pick),       32'h1);
        chk("reg.hold.valid",     32'(last_pick_valid), 32'h1);

        // Commit with nothing eligible: valid drops, index follows start.
        @(negedge clk);
        start_voq_num = 2'd3;
        voq_empty     = 4'b1111;
        pick_en       = 1'b1;
        @(posedge clk);
        #1;
        pick_en = 1'b0;
        chk("reg.none.last_pick", 32'(last_pick),       32'h3);
        chk("reg.none.valid",     32'(last_pick_valid), 32'h0);

        // Commit a valid pick again, then check asynchronous clear mid-cycle.
        @(negedge clk);
        start_voq_num = 2'd0;
        voq_empty     = 4'b0111;
        pick_en       = 1'b1;
        @(posedge clk);
        #1;
        pick_en = 1'b0;
        chk("reg.again.last_pick", 32'(last_pick),       32'h3);
        chk("reg.again.valid",     32'(last_pick_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset.last_pick", 32'(last_pick),       32'h0);
        chk("areset.valid",     32'(last_pick_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive comb sweep against the model.
        for (int s = 0; s < N; s++) begin
            for (int e = 0; e < 16; e++) begin
                for (int p = 0; p < 16; p++) begin
                    apply("sweep", s, 4'(e), 4'(p));
                end
            end
        end

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
